conv_pixel_scheduler: RTL and testbench

Pixel-level sequencer for the 32x32 conv engine. It walks every output pixel of a layer and issues patch-gather requests into a ping-pong pair of patch banks. It starts the conv engine on each filled bank, so gathering pixel n+1 overlaps computing pixel n. It buffers the engine's per-Cout-tile output bursts and turns them into masked 32-byte writes into the output feature-map buffer.

---
 rtl/conv_pixel_scheduler.sv | 261 ++++++++++++++++++++++++++
 tb/tb_conv_pixel_scheduler.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pixel_scheduler.sv
// Pixel-level sequencer for the conv engine.
// Walks every output pixel of a layer in raster order. Gathers patches into a
// ping-pong pair of patch banks and starts the engine on each filled bank, so
// gathering pixel n+1 overlaps computing pixel n. Engine result bursts are
// buffered in a small FIFO and written out as masked 32-byte writes.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, cfg_*         layer start pulse and configuration (latched on accept)
//   busy, done           layer in progress / one-cycle end-of-layer pulse
//   g_*                  patch-gather request/handshake
//   e_start/e_bank/e_done  engine start/handshake
//   e_out_*              engine result bursts
//   o_wr_*               output feature-map buffer write port
//   err_overflow         sticky: an engine burst was dropped (FIFO full)
module conv_pixel_scheduler #(
  parameter int unsigned OFM_AW     = 20,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [9:0]        cfg_h_in,
  input  logic [9:0]        cfg_w_in,
  input  logic [3:0]        cfg_kernel_size,
  input  logic [1:0]        cfg_stride,
  input  logic [10:0]       cfg_c_out,
  output logic              busy,
  output logic              done,
  output logic              g_start,
  output logic [9:0]        g_oy,
  output logic [9:0]        g_ox,
  output logic              g_bank,
  input  logic              g_done,
  output logic              e_start,
  output logic              e_bank,
  input  logic              e_done,
  input  logic              e_out_valid,
  input  logic [8:0]        e_out_ch_base,
  input  logic [5:0]        e_out_count,
  input  logic [255:0]      e_out_data,
  output logic              o_wr_en,
  output logic [OFM_AW-1:0] o_wr_addr,
  output logic [255:0]      o_wr_data,
  output logic [31:0]       o_wr_mask,
  input  logic              o_wr_ready,
  output logic              err_overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic [9:0]   oy;
    logic [9:0]   ox;
    logic [8:0]   ch_base;
    logic [5:0]   count;
    logic [255:0] data;
  } burst_t;

  state_e state_q, state_d;

  logic [9:0]  h_out_q, w_out_q;
  logic [10:0] c_out_q;
  logic [9:0]  gy_q, gx_q, ey_q, ex_q, tag_oy_q, tag_ox_q;
  logic        g_left_q, g_pend_q, gptr_q, g_start_q;
  logic        e_busy_q, eptr_q, e_start_q;
  logic [1:0]  bank_full_q, bank_full_d, full_eff;
  logic        err_q;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  burst_t          mem [FIFO_DEPTH];
  burst_t          head;

  // Kernel size does not change the output geometry (k=3 always uses pad 1).
  logic unused_kernel;
  assign unused_kernel = ^cfg_kernel_size;

  logic       stride2, dims_zero, start_acc, in_run;
  logic [9:0] hm1, wm1, h_out_calc, w_out_calc;
  logic       g_issue, g_fin, g_last, e_issue, e_fin, e_last;
  logic       fifo_empty, fifo_full, push, pop;

  always_comb begin
    stride2    = (cfg_stride == 2'd2);
    hm1        = cfg_h_in - 10'd1;
    wm1        = cfg_w_in - 10'd1;
    h_out_calc = (stride2 ? {1'b0, hm1[9:1]} : hm1) + 10'd1;
    w_out_calc = (stride2 ? {1'b0, wm1[9:1]} : wm1) + 10'd1;
    dims_zero  = (cfg_h_in == 10'd0) || (cfg_w_in == 10'd0);
    start_acc  = start && (state_q == StIdle);
    in_run     = (state_q == StRun);

    g_issue = in_run && g_left_q && !g_pend_q && !bank_full_q[gptr_q];
    g_fin   = g_done && g_pend_q;
    g_last  = (gy_q == h_out_q - 10'd1) && (gx_q == w_out_q - 10'd1);

    // Bypass the bank being filled this cycle so the engine can start at once.
    full_eff = bank_full_q;
    if (g_fin) full_eff[gptr_q] = 1'b1;
    e_issue = in_run && !e_busy_q && full_eff[eptr_q];
    e_fin   = e_done && e_busy_q;
    e_last  = (ey_q == h_out_q - 10'd1) && (ex_q == w_out_q - 10'd1);

    bank_full_d = bank_full_q;
    if (g_fin) bank_full_d[gptr_q] = 1'b1;
    if (e_fin) bank_full_d[eptr_q] = 1'b0;

    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
    push       = e_out_valid && !fifo_full;
    pop        = !fifo_empty && o_wr_ready;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = dims_zero ? StDone : StRun;
      StRun:   if (e_fin && e_last) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_out_q     <= '0;
      w_out_q     <= '0;
      c_out_q     <= '0;
      gy_q        <= '0;
      gx_q        <= '0;
      ey_q        <= '0;
      ex_q        <= '0;
      tag_oy_q    <= '0;
      tag_ox_q    <= '0;
      g_left_q    <= 1'b0;
      g_pend_q    <= 1'b0;
      gptr_q      <= 1'b0;
      g_start_q   <= 1'b0;
      e_busy_q    <= 1'b0;
      eptr_q      <= 1'b0;
      e_start_q   <= 1'b0;
      bank_full_q <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      g_start_q   <= 1'b0;
      e_start_q   <= 1'b0;
      bank_full_q <= bank_full_d;
      if (start_acc) begin
        h_out_q  <= h_out_calc;
        w_out_q  <= w_out_calc;
        c_out_q  <= cfg_c_out;
        gy_q     <= '0;
        gx_q     <= '0;
        ey_q     <= '0;
        ex_q     <= '0;
        g_left_q <= !dims_zero;
        g_pend_q <= 1'b0;
        gptr_q   <= 1'b0;
        e_busy_q <= 1'b0;
        eptr_q   <= 1'b0;
        err_q    <= 1'b0;
      end else if (e_out_valid && fifo_full) begin
        err_q <= 1'b1;
      end
      if (g_issue) begin
        g_start_q <= 1'b1;
        g_pend_q  <= 1'b1;
      end
      if (g_fin) begin
        g_pend_q <= 1'b0;
        gptr_q   <= ~gptr_q;
        if (g_last) begin
          g_left_q <= 1'b0;
        end else if (gx_q == w_out_q - 10'd1) begin
          gx_q <= '0;
          gy_q <= gy_q + 10'd1;
        end else begin
          gx_q <= gx_q + 10'd1;
        end
      end
      if (e_issue) begin
        e_start_q <= 1'b1;
        e_busy_q  <= 1'b1;
        tag_oy_q  <= ey_q;
        tag_ox_q  <= ex_q;
      end
      if (e_fin) begin
        e_busy_q <= 1'b0;
        eptr_q   <= ~eptr_q;
        if (!e_last) begin
          if (ex_q == w_out_q - 10'd1) begin
            ex_q <= '0;
            ey_q <= ey_q + 10'd1;
          end else begin
            ex_q <= ex_q + 10'd1;
          end
        end
      end
    end
  end

  // Engine output FIFO; a full FIFO drops the incoming burst even if popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= '{oy: tag_oy_q, ox: tag_ox_q, ch_base: e_out_ch_base,
                         count: e_out_count, data: e_out_data};
    end
  end

  assign head = mem[rd_ptr_q];

  logic [31:0] pix_idx;

  always_comb begin
    pix_idx   = 32'(head.oy) * 32'(w_out_q) + 32'(head.ox);
    o_wr_en   = !fifo_empty;
    o_wr_addr = '0;
    o_wr_data = '0;
    o_wr_mask = '0;
    if (!fifo_empty) begin
      o_wr_addr = OFM_AW'(pix_idx * 32'(c_out_q) + 32'(head.ch_base));
      o_wr_data = head.data;
      for (int unsigned i = 0; i < 32; i++) begin
        o_wr_mask[i] = (i < 32'(head.count));
      end
    end
  end

  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign g_start      = g_start_q;
  assign g_oy         = gy_q;
  assign g_ox         = gx_q;
  assign g_bank       = gptr_q;
  assign e_start      = e_start_q;
  assign e_bank       = eptr_q;
  assign err_overflow = err_q;

endmodule

// File: tb/tb_conv_pixel_scheduler.sv
module tb_conv_pixel_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   cfg_h_in, cfg_w_in;
  logic [3:0]   cfg_kernel_size;
  logic [1:0]   cfg_stride;
  logic [10:0]  cfg_c_out;
  logic         busy, done, g_start, g_bank, g_done, e_start, e_bank, e_done;
  logic [9:0]   g_oy, g_ox;
  logic         e_out_valid;
  logic [8:0]   e_out_ch_base;
  logic [5:0]   e_out_count;
  logic [255:0] e_out_data;
  logic         o_wr_en, o_wr_ready, err_overflow;
  logic [19:0]  o_wr_addr;
  logic [255:0] o_wr_data;
  logic [31:0]  o_wr_mask;

  conv_pixel_scheduler #(.OFM_AW(20), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_h_in(cfg_h_in), .cfg_w_in(cfg_w_in), .cfg_kernel_size(cfg_kernel_size),
    .cfg_stride(cfg_stride), .cfg_c_out(cfg_c_out),
    .busy(busy), .done(done),
    .g_start(g_start), .g_oy(g_oy), .g_ox(g_ox), .g_bank(g_bank), .g_done(g_done),
    .e_start(e_start), .e_bank(e_bank), .e_done(e_done),
    .e_out_valid(e_out_valid), .e_out_ch_base(e_out_ch_base),
    .e_out_count(e_out_count), .e_out_data(e_out_data),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_mask(o_wr_mask), .o_wr_ready(o_wr_ready), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder behaviour knobs
  int         g_lat = 5;
  int         e_lat = 5;
  int         nb    = 1;
  logic [8:0] bbase [4];
  logic [5:0] bcnt  [4];
  int         e_seq = 0;

  // Logs
  logic [9:0]   gs_oy [$];
  logic [9:0]   gs_ox [$];
  logic         gs_bank [$];
  int           gs_time [$];
  logic         eb_log [$];
  int           ed_time [$];
  logic [19:0]  wa_q [$];
  logic [31:0]  wm_q [$];
  logic [255:0] wd_q [$];
  int           done_cnt = 0;

  // Gather model: g_done g_lat cycles after g_start; bails out on reset.
  initial begin
    g_done = 1'b0;
    forever begin
      @(negedge clk);
      if (g_start && !rst) begin
        gs_oy.push_back(g_oy);
        gs_ox.push_back(g_ox);
        gs_bank.push_back(g_bank);
        gs_time.push_back(cyc);
        for (int i = 1; i < g_lat; i++) begin
          @(negedge clk);
          if (rst) break;
        end
        if (!rst) begin
          g_done = 1'b1;
          @(negedge clk);
          g_done = 1'b0;
        end
      end
    end
  end

  // Engine model: nb bursts right after e_start, e_done after e_lat cycles.
  // Burst data bytes are pixel_seq*4 + burst + 1.
  initial begin
    int seq;
    e_done = 1'b0;
    e_out_valid = 1'b0;
    e_out_ch_base = '0;
    e_out_count = '0;
    e_out_data = '0;
    forever begin
      @(negedge clk);
      if (e_start && !rst) begin
        eb_log.push_back(e_bank);
        seq = e_seq;
        e_seq++;
        for (int c = 0; c < e_lat; c++) begin
          if (c < nb) begin
            e_out_valid   = 1'b1;
            e_out_ch_base = bbase[c];
            e_out_count   = bcnt[c];
            e_out_data    = {32{8'(seq * 4 + c + 1)}};
          end else begin
            e_out_valid = 1'b0;
          end
          @(negedge clk);
          if (rst) break;
        end
        e_out_valid = 1'b0;
        if (!rst) begin
          ed_time.push_back(cyc);
          e_done = 1'b1;
          @(negedge clk);
          e_done = 1'b0;
        end
      end
    end
  end

  // Inputs change exactly at negedge; sample settled values shortly after.
  always @(negedge clk) begin
    #2;
    if (o_wr_en && o_wr_ready) begin
      wa_q.push_back(o_wr_addr);
      wm_q.push_back(o_wr_mask);
      wd_q.push_back(o_wr_data);
    end
    if (done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_layer(input int h, input int w, input int k, input int s,
                             input int c);
    @(negedge clk);
    cfg_h_in = 10'(h);
    cfg_w_in = 10'(w);
    cfg_kernel_size = 4'(k);
    cfg_stride = 2'(s);
    cfg_c_out = 11'(c);
    gs_oy.delete(); gs_ox.delete(); gs_bank.delete(); gs_time.delete();
    eb_log.delete(); ed_time.delete();
    wa_q.delete(); wm_q.delete(); wd_q.delete();
    done_cnt = 0;
    e_seq = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < max) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [63:0] snap;
    @(negedge clk);
    snap = {busy, done, g_start, g_oy, g_ox, g_bank, e_start, e_bank, o_wr_en,
            o_wr_mask, err_overflow};
    n_checks++;
    if (snap !== '0 || o_wr_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h/%h expected 0", snap, o_wr_addr);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [255:0] exp_d;
    g_lat = 5; e_lat = 5; nb = 1; bbase[0] = 9'd0; bcnt[0] = 6'd8; o_wr_ready = 1'b1;
    start_layer(4, 4, 3, 1, 8);
    repeat (20) @(negedge clk);
    // start while busy with a different config must be ignored
    cfg_h_in = 10'd2; cfg_w_in = 10'd2; cfg_c_out = 11'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: timeout waiting for done"); end
    n_checks++;
    if (wa_q.size() != 16) begin
      n_fail++;
      $display("FAIL basic_nwrites: got %0d expected 16", wa_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp_d = {32{8'(i * 4 + 1)}};
        n_checks++;
        if (wa_q[i] !== 20'(i * 8) || wm_q[i] !== 32'h0000_00FF || wd_q[i] !== exp_d) begin
          n_fail++;
          $display("FAIL basic_write[%0d]: got addr %0d mask %h data %h expected %0d %h %h",
                   i, wa_q[i], wm_q[i], wd_q[i][7:0], i * 8, 32'hFF, exp_d[7:0]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_err: got %b expected 0", err_overflow);
    end
    n_checks++;
    if (gs_oy.size() != 16 || gs_oy[5] !== 10'd1 || gs_ox[5] !== 10'd1 ||
        gs_oy[15] !== 10'd3 || gs_ox[15] !== 10'd3) begin
      n_fail++;
      $display("FAIL basic_gather_order: got n=%0d p5=(%0d,%0d) expected 16 (1,1)",
               gs_oy.size(), gs_oy[5], gs_ox[5]);
    end
  endtask

  task automatic test_stride2();
    bit ok;
    g_lat = 5; e_lat = 5; nb = 1; bbase[0] = 9'd0; bcnt[0] = 6'd32; o_wr_ready = 1'b1;
    start_layer(4, 4, 1, 2, 32);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL s2_done: timeout waiting for done"); end
    n_checks++;
    if (gs_oy.size() != 4) begin
      n_fail++;
      $display("FAIL s2_ngathers: got %0d expected 4", gs_oy.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (gs_oy[i] !== 10'(i / 2) || gs_ox[i] !== 10'(i % 2)) begin
          n_fail++;
          $display("FAIL s2_gather[%0d]: got (%0d,%0d) expected (%0d,%0d)",
                   i, gs_oy[i], gs_ox[i], i / 2, i % 2);
        end
      end
    end
    n_checks++;
    if (wa_q.size() != 4) begin
      n_fail++;
      $display("FAIL s2_nwrites: got %0d expected 4", wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa_q[i] !== 20'(i * 32) || wm_q[i] !== 32'hFFFF_FFFF) begin
          n_fail++;
          $display("FAIL s2_write[%0d]: got addr %0d mask %h expected %0d ffffffff",
                   i, wa_q[i], wm_q[i], i * 32);
        end
      end
    end
  endtask

  task automatic test_multi_burst();
    bit ok;
    g_lat = 5; e_lat = 6; nb = 2; o_wr_ready = 1'b1;
    bbase[0] = 9'd0;  bcnt[0] = 6'd32;
    bbase[1] = 9'd32; bcnt[1] = 6'd8;
    start_layer(2, 2, 3, 1, 40);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mb_done: timeout waiting for done"); end
    n_checks++;
    if (wa_q.size() != 8) begin
      n_fail++;
      $display("FAIL mb_nwrites: got %0d expected 8", wa_q.size());
    end else begin
      for (int p = 0; p < 4; p++) begin
        n_checks++;
        if (wa_q[2*p] !== 20'(p * 40) || wm_q[2*p] !== 32'hFFFF_FFFF ||
            wd_q[2*p][7:0] !== 8'(p * 4 + 1)) begin
          n_fail++;
          $display("FAIL mb_write_lo[%0d]: got addr %0d mask %h expected %0d ffffffff",
                   p, wa_q[2*p], wm_q[2*p], p * 40);
        end
        n_checks++;
        if (wa_q[2*p+1] !== 20'(p * 40 + 32) || wm_q[2*p+1] !== 32'h0000_00FF ||
            wd_q[2*p+1][7:0] !== 8'(p * 4 + 2)) begin
          n_fail++;
          $display("FAIL mb_write_hi[%0d]: got addr %0d mask %h expected %0d 000000ff",
                   p, wa_q[2*p+1], wm_q[2*p+1], p * 40 + 32);
        end
      end
    end
  endtask

  task automatic test_overlap();
    bit ok;
    g_lat = 2; e_lat = 50; nb = 1; bbase[0] = 9'd0; bcnt[0] = 6'd8; o_wr_ready = 1'b1;
    start_layer(2, 2, 3, 1, 8);
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovl_done: timeout waiting for done"); end
    n_checks++;
    if (gs_time.size() != 4 || ed_time.size() != 4 || eb_log.size() != 4) begin
      n_fail++;
      $display("FAIL ovl_counts: got g=%0d ed=%0d eb=%0d expected 4 4 4",
               gs_time.size(), ed_time.size(), eb_log.size());
    end else begin
      n_checks++;
      if (!(gs_time[1] < ed_time[0])) begin
        n_fail++;
        $display("FAIL ovl_second_gather: got g1=%0d e_done0=%0d expected g1 earlier",
                 gs_time[1], ed_time[0]);
      end
      n_checks++;
      if (!(gs_time[2] > ed_time[0])) begin
        n_fail++;
        $display("FAIL ovl_third_gather: got g2=%0d e_done0=%0d expected g2 later",
                 gs_time[2], ed_time[0]);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (eb_log[i] !== 1'(i % 2) || gs_bank[i] !== 1'(i % 2)) begin
          n_fail++;
          $display("FAIL ovl_bank[%0d]: got e=%b g=%b expected %0d",
                   i, eb_log[i], gs_bank[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int n;
    g_lat = 3; e_lat = 10; nb = 3; o_wr_ready = 1'b0;
    bbase[0] = 9'd0;  bcnt[0] = 6'd8;
    bbase[1] = 9'd8;  bcnt[1] = 6'd8;
    bbase[2] = 9'd16; bcnt[2] = 6'd8;
    start_layer(1, 1, 1, 1, 24);
    n = 0;
    while (ed_time.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_err: got %b expected 1", err_overflow);
    end
    n_checks++;
    if (wa_q.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_stalled: got writes=%0d busy=%b expected 0 1", wa_q.size(), busy);
    end
    o_wr_ready = 1'b1;
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ovf_done: timeout waiting for done"); end
    n_checks++;
    if (wa_q.size() != 2) begin
      n_fail++;
      $display("FAIL ovf_nwrites: got %0d expected 2", wa_q.size());
    end else begin
      n_checks++;
      if (wa_q[0] !== 20'd0 || wa_q[1] !== 20'd8 || wd_q[1][7:0] !== 8'd2) begin
        n_fail++;
        $display("FAIL ovf_writes: got %0d %0d data %h expected 0 8 02",
                 wa_q[0], wa_q[1], wd_q[1][7:0]);
      end
    end
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b expected 1", err_overflow);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n;
    logic [63:0] snap;
    g_lat = 3; e_lat = 30; nb = 1; bbase[0] = 9'd0; bcnt[0] = 6'd8; o_wr_ready = 1'b0;
    start_layer(4, 4, 3, 1, 8);
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_err_cleared_by_start: got %b expected 0", err_overflow);
    end
    n = 0;
    while (eb_log.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (o_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_pending_write: got %b expected 1", o_wr_en);
    end
    rst = 1'b1;
    @(negedge clk);
    snap = {busy, done, g_start, g_oy, g_ox, g_bank, e_start, e_bank, o_wr_en,
            o_wr_mask, err_overflow};
    n_checks++;
    if (snap !== '0 || o_wr_addr !== '0 || o_wr_data !== '0) begin
      n_fail++;
      $display("FAIL mr_outputs: got %h/%h expected 0", snap, o_wr_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (done_cnt != 0 || wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL mr_no_done: got done=%0d writes=%0d expected 0 0", done_cnt, wa_q.size());
    end
    g_lat = 2; e_lat = 4; o_wr_ready = 1'b1;
    start_layer(2, 2, 1, 1, 8);
    wait_done(1000, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mr_clean_done: timeout waiting for done"); end
    n_checks++;
    if (wa_q.size() != 4) begin
      n_fail++;
      $display("FAIL mr_clean_nwrites: got %0d expected 4", wa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (wa_q[i] !== 20'(i * 8) || wd_q[i][7:0] !== 8'(i * 4 + 1)) begin
          n_fail++;
          $display("FAIL mr_clean_write[%0d]: got addr %0d data %h expected %0d %h",
                   i, wa_q[i], wd_q[i][7:0], i * 8, 8'(i * 4 + 1));
        end
      end
    end
  endtask

  task automatic test_zero_dims();
    bit ok;
    o_wr_ready = 1'b1;
    start_layer(0, 4, 1, 1, 8);
    wait_done(20, ok);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_done: timeout waiting for done"); end
    n_checks++;
    if (gs_oy.size() != 0 || wa_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_activity: got gathers=%0d writes=%0d busy=%b expected 0 0 0",
               gs_oy.size(), wa_q.size(), busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_h_in = '0; cfg_w_in = '0; cfg_kernel_size = '0; cfg_stride = 2'd1; cfg_c_out = '0;
    o_wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bbase[i] = '0;
      bcnt[i]  = '0;
    end
    test_reset();
    test_basic();
    test_stride2();
    test_multi_burst();
    test_overlap();
    test_overflow();
    test_mid_reset();
    test_zero_dims();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
